// File: rtl/uart_responder_pkg.sv
// Shared command codes, response framing bytes and responder FSM encoding.
// The command codes are also used by the UART receive router.
package uart_responder_pkg;

    localparam logic [7:0] CMD_DIGIT_READ  = 8'hCC;
    localparam logic [7:0] CMD_SCORES_READ = 8'hCD;
    localparam logic [7:0] RSP_SCORES_HDR1 = 8'hDD;
    localparam logic [7:0] RSP_SCORES_HDR2 = 8'h77;
    localparam logic [7:0] RSP_NO_RESULT   = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT
    } state_e;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_DIGIT_READ) || (b == CMD_SCORES_READ);
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 byte serializer: one start bit, eight data bits LSB-first, one stop bit.
// busy drops during the final clock of the stop bit so a caller can chain bytes.
module uart_tx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       start,
    output logic       tx,
    output logic       busy
);

    localparam int BIT = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(BIT + 1);
    localparam logic [CW-1:0] BIT_M1 = CW'(BIT - 1);

    logic          act_q, act_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [8:0]    frm_q, frm_d;
    logic          tx_q, tx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q <= 1'b0;
            cnt_q <= '0;
            bit_q <= '0;
            frm_q <= '1;
            tx_q  <= 1'b1;
        end else begin
            act_q <= act_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            frm_q <= frm_d;
            tx_q  <= tx_d;
        end
    end

    always_comb begin
        act_d = act_q;
        cnt_d = cnt_q;
        bit_d = bit_q;
        frm_d = frm_q;
        tx_d  = tx_q;
        if (!act_q) begin
            if (start) begin
                act_d = 1'b1;
                cnt_d = '0;
                bit_d = '0;
                frm_d = {1'b1, data};
                tx_d  = 1'b0;
            end
        end else if (cnt_q == BIT_M1) begin
            cnt_d = '0;
            if (bit_q == 4'd9) begin
                act_d = 1'b0;
                tx_d  = 1'b1;
            end else begin
                tx_d  = frm_q[0];
                frm_d = {1'b1, frm_q[8:1]};
                bit_d = bit_q + 4'd1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign tx   = tx_q;
    assign busy = act_q && !(bit_q == 4'd9 && cnt_q == BIT_M1);

endmodule

// File: rtl/uart_responder.sv
// Serializes digit and score response packets for commands from the RX router.
// Holds a snapshot of the inference result and a one-deep pending command slot.
module uart_responder
    import uart_responder_pkg::*;
#(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [7:0]                     cmd_rx_data,
    input  logic                           cmd_rx_ready,
    input  logic                           result_valid,
    input  logic [3:0]                     predicted_digit,
    input  logic [NUM_CLASSES*SCORE_W-1:0] scores,
    output logic                           tx,
    output logic                           busy
);

    localparam int SV_W    = NUM_CLASSES * SCORE_W;
    localparam int NB      = SV_W / 8;
    localparam int SCR_LEN = NB + 4;
    localparam int IDX_W   = ($clog2(SCR_LEN) > 6) ? $clog2(SCR_LEN) : 6;
    localparam logic [IDX_W-1:0] LEN_SCR = IDX_W'(SCR_LEN);
    localparam logic [IDX_W-1:0] LEN_DIG = IDX_W'(2);
    localparam logic [IDX_W-1:0] TRL1    = IDX_W'(SCR_LEN - 2);
    localparam logic [IDX_W-1:0] TRL2    = IDX_W'(SCR_LEN - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic             scr_q, scr_d;
    logic             vld_q, vld_d;
    logic [3:0]       dig_q, dig_d;
    logic [SV_W-1:0]  sc_q, sc_d;
    logic             pend_q, pend_d;
    logic             pscr_q, pscr_d;

    logic             cmd_ok, cmd_scr, active, last, tx_busy;
    logic             snap_en, snap_scr, tx_start;
    logic [7:0]       tx_byte;
    logic [IDX_W-1:0] off;

    assign cmd_ok  = cmd_rx_ready && is_cmd(cmd_rx_data);
    assign cmd_scr = (cmd_rx_data == CMD_SCORES_READ);
    assign active  = (state_q != ST_IDLE);
    assign last    = (idx_q == len_q - IDX_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            scr_q   <= 1'b0;
            vld_q   <= 1'b0;
            dig_q   <= '0;
            sc_q    <= '0;
            pend_q  <= 1'b0;
            pscr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            scr_q   <= scr_d;
            vld_q   <= vld_d;
            dig_q   <= dig_d;
            sc_q    <= sc_d;
            pend_q  <= pend_d;
            pscr_q  <= pscr_d;
        end
    end

    // A pending or same-cycle command relaunches without passing through IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pend_q)      state_d = ST_LOAD;
                else if (cmd_ok) state_d = ST_START;
            end
            ST_LOAD:  state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!tx_busy) begin
                    if (!last)                 state_d = ST_START;
                    else if (pend_q || cmd_ok) state_d = ST_LOAD;
                    else                       state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        snap_en  = 1'b0;
        snap_scr = cmd_scr;
        if (state_q == ST_IDLE && !pend_q && cmd_ok) snap_en = 1'b1;
        if (state_q == ST_LOAD) begin
            snap_en  = 1'b1;
            snap_scr = pscr_q;
        end
        idx_d  = idx_q;
        len_d  = len_q;
        scr_d  = scr_q;
        vld_d  = vld_q;
        dig_d  = dig_q;
        sc_d   = sc_q;
        pend_d = pend_q;
        pscr_d = pscr_q;
        if (snap_en) begin
            scr_d = snap_scr;
            vld_d = result_valid;
            dig_d = predicted_digit;
            sc_d  = scores;
            idx_d = '0;
            len_d = snap_scr ? LEN_SCR : LEN_DIG;
        end else if (state_q == ST_WAIT && !tx_busy && !last) begin
            idx_d = idx_q + IDX_W'(1);
        end
        if (cmd_ok && active && !pend_q) begin
            pend_d = 1'b1;
            pscr_d = cmd_scr;
        end else if (state_q == ST_LOAD) begin
            pend_d = 1'b0;
        end
    end

    assign off = idx_q - IDX_W'(2);

    always_comb begin
        tx_start = (state_q == ST_START);
        busy     = active;
        tx_byte  = 8'h00;
        if (!scr_q) begin
            if (idx_q == '0) tx_byte = CMD_DIGIT_READ;
            else             tx_byte = vld_q ? {4'h0, dig_q} : RSP_NO_RESULT;
        end else begin
            unique case (1'b1)
                idx_q == '0:           tx_byte = RSP_SCORES_HDR1;
                idx_q == IDX_W'(1):    tx_byte = RSP_SCORES_HDR2;
                idx_q == TRL1:         tx_byte = RSP_SCORES_HDR2;
                idx_q == TRL2:         tx_byte = RSP_SCORES_HDR1;
                default: tx_byte = vld_q ? sc_q[{off, 3'b000} +: 8] : 8'h00;
            endcase
        end
    end

    uart_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) u_tx (
        .clk  (clk),
        .rst_n(rst_n),
        .data (tx_byte),
        .start(tx_start),
        .tx   (tx),
        .busy (tx_busy)
    );

endmodule

// File: tb/tb_uart_responder.sv
// Directed bench for uart_responder: decodes the TX line and checks packets.
// Uses a 16-clock bit period so full score packets stay short.
module tb_uart_responder;

    localparam int CLK_FREQ = 1600;
    localparam int BAUD     = 100;
    localparam int BIT      = CLK_FREQ / BAUD;
    localparam int NC       = 10;
    localparam int SW       = 32;
    localparam int SV       = NC * SW;
    localparam int NB       = SV / 8;
    localparam int PLEN     = NB + 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    cmd_rx_data;
    logic          cmd_rx_ready;
    logic          result_valid;
    logic [3:0]    predicted_digit;
    logic [SV-1:0] scores;
    logic          tx;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    uart_responder #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD),
        .NUM_CLASSES(NC),
        .SCORE_W    (SW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_rx_data    (cmd_rx_data),
        .cmd_rx_ready   (cmd_rx_ready),
        .result_valid   (result_valid),
        .predicted_digit(predicted_digit),
        .scores         (scores),
        .tx             (tx),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] d);
        cmd_rx_data  = d;
        cmd_rx_ready = 1'b1;
        @(negedge clk);
        cmd_rx_ready = 1'b0;
    endtask

    // Returns at the middle of the stop bit; t0 is the start-bit cycle.
    task automatic rx(output logic [7:0] b, output int t0);
        int n = 0;
        b  = '0;
        t0 = 0;
        while (tx !== 1'b0 && n < 40 * BIT) begin
            @(negedge clk);
            n++;
        end
        chk("rx_start_seen", {31'b0, tx === 1'b0}, 32'd1);
        if (tx !== 1'b0) return;
        t0 = cyc;
        repeat (BIT / 2) @(negedge clk);
        chk("rx_start_bit", {31'b0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge clk);
            b[i] = tx;
        end
        repeat (BIT) @(negedge clk);
        chk("rx_stop_bit", {31'b0, tx}, 32'd1);
    endtask

    function automatic logic [7:0] exp_byte(input int i, input bit v,
                                            input logic [SV-1:0] sc);
        if (i == 0 || i == NB + 3) return 8'hDD;
        if (i == 1 || i == NB + 2) return 8'h77;
        return v ? sc[(i - 2) * 8 +: 8] : 8'h00;
    endfunction

    task automatic idle_window(input string tag, input int n);
        int act = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) act++;
        end
        chk(tag, act, 32'd0);
    endtask

    logic [SV-1:0] orig, alt;
    logic [7:0]    b;
    logic [7:0]    rxb [PLEN];
    int            t0, t1, ts, te, n;

    initial begin
        for (int k = 0; k < NC; k++) begin
            orig[k*SW +: SW] = k * 32'h01010101 - 32'd5;
            alt[k*SW +: SW]  = ~(k * 32'h01010101 - 32'd5);
        end
        rst_n           = 1'b0;
        cmd_rx_data     = 8'h00;
        cmd_rx_ready    = 1'b0;
        result_valid    = 1'b0;
        predicted_digit = 4'd0;
        scores          = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        strobe(8'h42);
        chk("ign_busy", {31'b0, busy}, 32'd0);
        idle_window("ign_quiet", 3 * BIT);

        result_valid    = 1'b1;
        predicted_digit = 4'd7;
        strobe(8'hCC);
        ts = cyc;
        chk("lat_busy", {31'b0, busy}, 32'd1);
        chk("lat_tx_hi", {31'b0, tx}, 32'd1);
        @(negedge clk);
        chk("lat_tx_fall", {31'b0, tx}, 32'd0);
        rx(b, t0);
        chk("dig_b0", b, 32'hCC);
        rx(b, t1);
        chk("dig_b1", b, 32'h07);
        chk("dig_gap", {31'b0, (t1 - t0 >= 10 * BIT) &&
                               (t1 - t0 <= 10 * BIT + 2)}, 32'd1);
        repeat (BIT / 2 - 1) @(negedge clk);
        chk("dig_busy_last", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("dig_busy_end", {31'b0, busy}, 32'd0);
        te = cyc;
        chk("dig_busy_len", {31'b0, (te - ts >= 20 * BIT + 1) &&
                                    (te - ts <= 20 * BIT + 4)}, 32'd1);

        result_valid = 1'b0;
        strobe(8'hCC);
        rx(b, t0);
        chk("nr_dig_b0", b, 32'hCC);
        rx(b, t0);
        chk("nr_dig_b1", b, 32'hFF);
        repeat (BIT) @(negedge clk);
        chk("nr_dig_idle", {31'b0, busy}, 32'd0);

        result_valid = 1'b1;
        scores       = orig;
        strobe(8'hCD);
        for (int i = 0; i < PLEN; i++) begin
            rx(rxb[i], t0);
            chk($sformatf("scr_b%0d", i), rxb[i], exp_byte(i, 1'b1, orig));
        end
        chk("scr_c0_b0", rxb[2], 32'hFB);
        chk("scr_c0_b3", rxb[5], 32'hFF);
        chk("scr_c1_b0", rxb[6], 32'hFC);
        chk("scr_c1_b1", rxb[7], 32'h00);
        chk("scr_c1_b3", rxb[9], 32'h01);
        repeat (BIT) @(negedge clk);
        chk("scr_len44", {31'b0, busy}, 32'd0);

        result_valid = 1'b0;
        strobe(8'hCD);
        for (int i = 0; i < PLEN; i++) begin
            rx(b, t0);
            chk($sformatf("nr_scr_b%0d", i), b, exp_byte(i, 1'b0, orig));
        end
        repeat (BIT) @(negedge clk);
        chk("nr_scr_idle", {31'b0, busy}, 32'd0);

        result_valid    = 1'b1;
        predicted_digit = 4'd9;
        scores          = orig;
        strobe(8'hCD);
        rx(b, t0);
        chk("pend_b0", b, 32'hDD);
        rx(b, t0);
        chk("pend_b1", b, 32'h77);
        scores          = alt;
        predicted_digit = 4'd3;
        strobe(8'hCC);
        @(negedge clk);
        strobe(8'hCC);
        for (int i = 2; i < PLEN; i++) begin
            rx(b, t0);
            chk($sformatf("pend_scr_b%0d", i), b, exp_byte(i, 1'b1, orig));
        end
        rx(b, t1);
        chk("pend_dig_b0", b, 32'hCC);
        chk("pend_gap", {31'b0, (t1 - t0 >= 10 * BIT) &&
                                (t1 - t0 <= 10 * BIT + 2)}, 32'd1);
        rx(b, t0);
        chk("pend_dig_b1", b, 32'h03);
        repeat (BIT) @(negedge clk);
        chk("pend_done", {31'b0, busy}, 32'd0);
        idle_window("pend_dropped", 25 * BIT);

        strobe(8'hCD);
        for (int i = 0; i < 3; i++) rx(b, t0);
        strobe(8'hCC);
        n = 0;
        while (tx !== 1'b0 && n < 40 * BIT) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_low", {31'b0, tx}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_tx", {31'b0, tx}, 32'd1);
        chk("rst_async_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_window("rst_quiet", 30 * BIT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_responder.md
# uart_responder

Transmit-side counterpart of the system's UART receive router. Accepts the one-cycle command pulses produced on the router's command interface (0xCC digit request, 0xCD scores request), snapshots the current inference result, and serializes a framed response packet to the PC over the single system TX line. It is the only UART transmitter in the design.

## Interface
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- BAUD_RATE, 115200, serial rate; bit period = CLK_FREQ/BAUD_RATE clocks (868 at defaults)
- NUM_CLASSES, 10, number of output scores
- SCORE_W, 32, score width in bits, signed two's complement, multiple of 8

- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- cmd_rx_data  in  8  command byte from the router
- cmd_rx_ready  in  1  one-cycle strobe qualifying cmd_rx_data
- result_valid  in  1  high while predicted_digit and scores hold a completed inference
- predicted_digit  in  4  argmax class, 0..9
- scores  in  NUM_CLASSES*SCORE_W  flat score vector; class k at bits [k*SCORE_W +: SCORE_W]
- tx  out  1  UART TX line, idles high
- busy  out  1  high from command acceptance until the last stop bit of the packet completes

## Operation
- Packets:
  - Digit (0xCC): 2 bytes: 0xCC, then digit (0x00..0x09), or 0xFF if result_valid was low at snapshot.
  - Scores (0xCD): 0xDD 0x77, then NUM_CLASSES×SCORE_W/8 bytes (class 0 first, each score little-endian), then 0x77 0xDD. Total 44 bytes at defaults. If result_valid was low at snapshot, all score bytes are 0x00.
- Any other cmd_rx_data value on a strobe is ignored with no state change.
- Snapshot: on acceptance, capture the command, result_valid, predicted_digit and the full scores vector into internal registers. Input changes during transmission do not affect the packet in flight.
- Pending slot: one-deep.
  - A valid command arriving while busy is stored if the slot is empty. It is launched immediately after the current packet's last stop bit, with its snapshot taken at launch.
  - A command arriving while the slot is full is dropped.
- FSM:
  - IDLE: wait for a command or a pending entry.
  - LOAD: snapshot, clear the byte index, select the packet length.
  - START: pulse the byte-serializer start with the indexed byte.
  - WAIT: wait for the serializer to finish. If index = length−1, go to IDLE; else increment the index and go to START.
- Byte index counter width ≥ 6 bits. Byte selection is combinational from index and the snapshot. Header and trailer offsets are derived from NUM_CLASSES and SCORE_W.

## Timing
- Reset values: tx=1, busy=0, state=IDLE, index=0, pending empty, snapshot registers 0.
- Reset asserted mid-byte forces tx high asynchronously and discards the packet and the pending command. The stream resumes only on a new command.
- Latency: the cmd_rx_ready strobe at cycle N gives busy=1 at N+1 and the start-bit falling edge on tx at N+2.
- Each byte is 1 start bit (0), 8 data bits LSB-first, and 1 stop bit (1), each exactly CLK_FREQ/BAUD_RATE clocks. Bytes are back-to-back with at most 2 idle clocks of extra stop time between them.
- busy deasserts the cycle after the final stop bit ends, unless pending is non-empty. In that case busy stays high and the next start bit follows within 2 clocks.
- A strobe in the same cycle as the final stop bit ends is treated as arriving while busy. It enters the pending slot if that slot is empty.
- Packet time at defaults: digit ≈ 17,360 clocks, scores ≈ 381,920 clocks.

## Structure
- Shared package constants: CMD_DIGIT_READ=0xCC, CMD_SCORES_READ=0xCD, RSP_SCORES_HDR1=0xDD, RSP_SCORES_HDR2=0x77, RSP_NO_RESULT=0xFF, plus the FSM state encoding. The command codes are shared with the RX router.
- One sub-module: uart_tx (CLK_FREQ, BAUD_RATE; ports clk, rst_n, data[7:0], start, tx, busy). It holds the bit-period counter and the shift register. uart_responder owns framing, snapshot and pending logic.

## Test plan
- Digit request: result_valid=1, digit=7; strobe 0xCC → tx decodes 0xCC 0x07; busy high about 17,360 clocks; first falling edge 2 clocks after the strobe.
- Scores request: scores[k]=k×0x01010101−5 (signed); strobe 0xCD → tx decodes 0xDD 0x77, then score bytes with class 0 first, little-endian (class 0 = FB FF FF FF), then 0x77 0xDD; 44 bytes total.
- No result: result_valid=0; strobe 0xCC → 0xCC 0xFF. Strobe 0xCD → header, 40×0x00, trailer.
- Snapshot and pending: strobe 0xCD, change scores mid-packet, strobe 0xCC and 0xCC again → original scores are sent intact, followed by exactly one digit packet; the second 0xCC is dropped.
- Ignore and reset: strobe 0x42 → tx stays high and busy stays 0. Start a scores packet and assert rst_n=0 mid-byte → tx goes high the same cycle; after release no bytes are sent without a new strobe.
